// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Purpose  : MEM/WB pipeline register with result select, load alignment,
//            stall/flush control and a retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [2:0]        wb_sel,
  input  logic [2:0]        funct3,
  input  logic              reg_write,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   imm,
  output logic              wb_valid,
  output logic              rd_we,
  output logic [REG_AW-1:0] rd_waddr,
  output logic [XLEN-1:0]   rd_data,
  output logic [CNT_W-1:0]  instret
);

  localparam int c_offw = $clog2(XLEN / 8);

  logic [c_offw-1:0] w_off;
  logic [XLEN-1:0]   w_shifted;
  logic [XLEN-1:0]   w_word_s;
  logic [XLEN-1:0]   w_word_u;
  logic [XLEN-1:0]   w_load;
  logic [XLEN-1:0]   w_result;
  logic              w_we;
  logic              w_capture;

  logic              r_valid;
  logic              r_we;
  logic [REG_AW-1:0] r_waddr;
  logic [XLEN-1:0]   r_data;
  logic [CNT_W-1:0]  r_instret;

  // Misaligned offsets simply shift zeros in from the top.
  assign w_off     = alu_result[c_offw-1:0];
  assign w_shifted = mem_rdata >> {w_off, 3'b000};
  assign w_word_s  = XLEN'($signed(w_shifted[31:0]));
  assign w_word_u  = XLEN'(w_shifted[31:0]);

  always_comb begin
    w_load = w_word_s;
    case (funct3)
      3'b000:  w_load = XLEN'($signed(w_shifted[7:0]));
      3'b100:  w_load = XLEN'(w_shifted[7:0]);
      3'b001:  w_load = XLEN'($signed(w_shifted[15:0]));
      3'b101:  w_load = XLEN'(w_shifted[15:0]);
      3'b010:  w_load = w_word_s;
      3'b110:  w_load = (XLEN == 64) ? w_word_u : w_word_s;
      3'b011:  w_load = (XLEN == 64) ? w_shifted : w_word_s;
      3'b111:  w_load = mem_rdata;
      default: w_load = w_word_s;
    endcase
  end

  always_comb begin
    w_result = alu_result;
    case (wb_sel)
      3'd1:    w_result = w_load;
      3'd2:    w_result = pc + XLEN'(4);
      3'd3:    w_result = imm;
      3'd4:    w_result = pc + imm;
      default: w_result = alu_result;
    endcase
  end

  // x0 is hard-wired zero, so a write to it is never issued.
  assign w_we      = in_valid & reg_write & (rd_addr != '0);
  assign w_capture = ~flush & ~stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_data    <= '0;
      r_instret <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
    end else if (w_capture) begin
      r_valid <= in_valid;
      r_we    <= w_we;
      r_waddr <= rd_addr;
      r_data  <= w_result;
      if (in_valid) begin
        r_instret <= r_instret + CNT_W'(1);
      end
    end
  end

  assign wb_valid = r_valid;
  assign rd_we    = r_we;
  assign rd_waddr = r_waddr;
  assign rd_data  = r_data;
  assign instret  = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage
// Purpose  : Self-checking bench for wb_stage (XLEN 32/64, narrow counter).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  wb_sel = 3'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        reg_write = 1'b0;
  logic [4:0]  rd_addr = 5'd0;
  logic [63:0] alu_result = 64'd0;
  logic [63:0] mem_rdata = 64'd0;
  logic [63:0] pc = 64'd0;
  logic [63:0] imm = 64'd0;

  logic        v32, we32, v64, we64, v4, we4;
  logic [4:0]  wa32, wa64, wa4;
  logic [31:0] d32, d4;
  logic [63:0] d64, ir32, ir64;
  logic [3:0]  ir4;

  int checks = 0;
  int errors = 0;

  logic        e_valid, e_we;
  logic [4:0]  e_waddr;
  logic [63:0] e_d32, e_d64, e_cnt;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32), .REG_AW(5), .CNT_W(64)) u_d32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .wb_sel(wb_sel), .funct3(funct3), .reg_write(reg_write), .rd_addr(rd_addr),
    .alu_result(alu_result[31:0]), .mem_rdata(mem_rdata[31:0]), .pc(pc[31:0]),
    .imm(imm[31:0]), .wb_valid(v32), .rd_we(we32), .rd_waddr(wa32),
    .rd_data(d32), .instret(ir32));

  wb_stage #(.XLEN(64), .REG_AW(5), .CNT_W(64)) u_d64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .wb_sel(wb_sel), .funct3(funct3), .reg_write(reg_write), .rd_addr(rd_addr),
    .alu_result(alu_result), .mem_rdata(mem_rdata), .pc(pc), .imm(imm),
    .wb_valid(v64), .rd_we(we64), .rd_waddr(wa64), .rd_data(d64), .instret(ir64));

  wb_stage #(.XLEN(32), .REG_AW(5), .CNT_W(4)) u_d4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .wb_sel(wb_sel), .funct3(funct3), .reg_write(reg_write), .rd_addr(rd_addr),
    .alu_result(alu_result[31:0]), .mem_rdata(mem_rdata[31:0]), .pc(pc[31:0]),
    .imm(imm[31:0]), .wb_valid(v4), .rd_we(we4), .rd_waddr(wa4),
    .rd_data(d4), .instret(ir4));

  // Reference: load result built byte-by-byte from a little-endian word.
  function automatic logic [63:0] ref_load(int xlen, logic [2:0] f3,
                                           logic [63:0] alu, logic [63:0] mem);
    int nb = xlen / 8;
    int off = int'(alu[2:0]) & (nb - 1);
    int sz;
    bit sg;
    logic [63:0] sh = 64'd0;
    logic [63:0] val = 64'd0;
    for (int i = 0; i < nb; i++)
      if (i + off < nb) sh[i*8 +: 8] = mem[(i+off)*8 +: 8];
    case (f3)
      3'd0: begin sz = 1; sg = 1; end
      3'd4: begin sz = 1; sg = 0; end
      3'd1: begin sz = 2; sg = 1; end
      3'd5: begin sz = 2; sg = 0; end
      3'd6: begin sz = 4; sg = (xlen == 32); end
      3'd3: begin sz = (xlen == 64) ? 8 : 4; sg = (xlen == 32); end
      3'd7: return mem;
      default: begin sz = 4; sg = 1; end
    endcase
    for (int i = 0; i < sz; i++) val[i*8 +: 8] = sh[i*8 +: 8];
    if (sg && sh[sz*8-1])
      for (int i = sz * 8; i < 64; i++) val[i] = 1'b1;
    return val;
  endfunction

  function automatic logic [63:0] ref_result(int xlen);
    logic [63:0] mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    logic [63:0] r;
    case (wb_sel)
      3'd1:    r = ref_load(xlen, funct3, alu_result & mask, mem_rdata & mask);
      3'd2:    r = pc + 64'd4;
      3'd3:    r = imm;
      3'd4:    r = pc + imm;
      default: r = alu_result;
    endcase
    return r & mask;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(string tag);
    chk({tag, ".valid32"}, 64'(v32), 64'(e_valid));
    chk({tag, ".we32"},    64'(we32), 64'(e_we));
    chk({tag, ".waddr32"}, 64'(wa32), 64'(e_waddr));
    chk({tag, ".data32"},  64'(d32),  e_d32);
    chk({tag, ".cnt32"},   ir32,      e_cnt);
    chk({tag, ".valid64"}, 64'(v64), 64'(e_valid));
    chk({tag, ".we64"},    64'(we64), 64'(e_we));
    chk({tag, ".waddr64"}, 64'(wa64), 64'(e_waddr));
    chk({tag, ".data64"},  d64,       e_d64);
    chk({tag, ".cnt64"},   ir64,      e_cnt);
    chk({tag, ".valid4"},  64'(v4),  64'(e_valid));
    chk({tag, ".we4"},     64'(we4), 64'(e_we));
    chk({tag, ".waddr4"},  64'(wa4), 64'(e_waddr));
    chk({tag, ".data4"},   64'(d4),  e_d32);
    chk({tag, ".cnt4"},    64'(ir4), {60'd0, e_cnt[3:0]});
  endtask

  task automatic model_clear();
    e_valid = 1'b0; e_we = 1'b0; e_waddr = 5'd0;
    e_d32 = 64'd0; e_d64 = 64'd0; e_cnt = 64'd0;
  endtask

  // Advance the model by one edge using the current inputs, then compare.
  task automatic tick(string tag);
    if (flush) begin
      e_valid = 1'b0;
      e_we    = 1'b0;
    end else if (!stall) begin
      e_valid = in_valid;
      e_we    = in_valid && reg_write && (rd_addr != 5'd0);
      e_waddr = rd_addr;
      e_d32   = ref_result(32);
      e_d64   = ref_result(64);
      if (in_valid) e_cnt = e_cnt + 64'd1;
    end
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  task automatic set_in(logic iv, logic [2:0] sel, logic [2:0] f3, logic rw,
                        logic [4:0] ra, logic [63:0] alu, logic [63:0] mem);
    in_valid = iv; wb_sel = sel; funct3 = f3; reg_write = rw;
    rd_addr = ra; alu_result = alu; mem_rdata = mem;
  endtask

  task automatic async_reset(string tag);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    model_clear();
    chk_all(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    model_clear();
    #12;
    chk_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // First capture after reset.
    set_in(1, 3'd0, 3'd0, 1, 5'd5, 64'h1234, 64'd0);
    tick("alu");
    chk("alu.explicit_data", 64'(d32), 64'h1234);
    chk("alu.explicit_cnt", ir32, 64'd1);

    // Load formatting at byte offset 2.
    set_in(1, 3'd1, 3'b000, 1, 5'd7, 64'h2, 64'h80FF7F01);
    tick("lb");
    chk("lb.explicit", 64'(d32), 64'hFFFF_FFFF);
    funct3 = 3'b100; tick("lbu");
    chk("lbu.explicit", 64'(d32), 64'h0000_00FF);
    funct3 = 3'b001; tick("lh");
    chk("lh.explicit", 64'(d32), 64'hFFFF_80FF);
    for (int f = 0; f < 8; f++) begin
      funct3 = 3'(f);
      mem_rdata = 64'hF1E2_D3C4_85A6_9788;
      alu_result = 64'h5;
      tick("loadsweep");
    end

    // Result source sweep.
    pc = 64'h100; imm = 64'h20; alu_result = 64'hABCD;
    for (int s = 0; s < 8; s++) begin
      wb_sel = 3'(s);
      tick("selsweep");
    end
    wb_sel = 3'd4; tick("sel4");
    chk("sel4.explicit", 64'(d32), 64'h120);

    // Write to x0 must not enable the register file.
    set_in(1, 3'd0, 3'd0, 1, 5'd0, 64'h55, 64'd0);
    tick("x0");
    chk("x0.we", 64'(we32), 64'd0);

    // Stall with changing inputs, then stall+flush.
    set_in(1, 3'd0, 3'd0, 1, 5'd9, 64'h77, 64'd0);
    tick("prestall");
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_in(1, 3'(k), 3'd2, 1, 5'(10 + k), 64'($urandom), 64'($urandom));
      tick("stall");
    end
    flush = 1'b1;
    tick("stallflush");
    stall = 1'b0;
    tick("flush");
    flush = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      stall      = ($urandom_range(0, 4) == 0);
      flush      = ($urandom_range(0, 7) == 0);
      wb_sel     = 3'($urandom_range(0, 7));
      funct3     = 3'($urandom_range(0, 7));
      reg_write  = ($urandom_range(0, 3) != 0);
      rd_addr    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      alu_result = {32'($urandom), 32'($urandom)};
      mem_rdata  = {32'($urandom), 32'($urandom)};
      pc         = {32'($urandom), 32'($urandom)};
      imm        = ($urandom_range(0, 1) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {32'($urandom), 32'($urandom)};
      tick("rand");
    end

    // Counter wrap on the 4-bit instance.
    stall = 1'b0; flush = 1'b0;
    async_reset("rst_mid");
    for (int n = 0; n < 17; n++) begin
      set_in(1, 3'd0, 3'd0, 1, 5'(n + 1), 64'(n), 64'd0);
      tick("wrap");
    end
    chk("wrap.explicit", 64'(ir4), 64'd1);
    async_reset("rst_after_wrap");
    tick("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Registered, parametrised RISC-V writeback stage. Replaces the flat combinational result mux with a MEM/WB pipeline register and an encoded source select. Adds load-data alignment with sign/zero extension, stall/flush control and a retired-instruction counter. Sits between the memory stage and the register file write port; its registered outputs also feed the forwarding unit.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
REG_AW, 5, register address width
CNT_W, 64, width of the retired-instruction counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-high reset
in_valid  input  1  memory-stage slot holds a real instruction
stall  input  1  hold the WB register contents
flush  input  1  kill the incoming instruction
wb_sel  input  3  result source: 0 ALU, 1 MEM, 2 PC+4, 3 IMM, 4 PC+IMM, 5-7 reserved
funct3  input  3  load size/sign (RISC-V load encoding)
reg_write  input  1  instruction writes rd
rd_addr  input  REG_AW  destination register
alu_result  input  XLEN  ALU result; also the load address
mem_rdata  input  XLEN  raw aligned memory word
pc  input  XLEN  instruction PC
imm  input  XLEN  decoded immediate
wb_valid  output  1  WB register holds a live instruction
rd_we  output  1  register-file write enable
rd_waddr  output  REG_AW  register-file write address
rd_data  output  XLEN  register-file write data
instret  output  CNT_W  retired-instruction count

Behaviour:
- Reset (asynchronous, immediate): wb_valid=0, rd_we=0, rd_waddr=0, rd_data=0, instret=0.
- Result selection (combinational, before the register):
  - sel 0 → alu_result.
  - sel 1 → formatted load.
  - sel 2 → pc+4.
  - sel 3 → imm.
  - sel 4 → pc+imm.
  - sel 5-7 → alu_result.
  - All sums are modulo 2^XLEN.
- Load formatting:
  - Byte offset off = alu_result[log2(XLEN/8)-1:0].
  - Shift mem_rdata right by off*8 bits, zero-filling.
  - funct3 000 LB: sign-extend bits [7:0].
  - 100 LBU: zero-extend [7:0].
  - 001 LH: sign-extend [15:0].
  - 101 LHU: zero-extend [15:0].
  - 010 LW: sign-extend [31:0].
  - 110 LWU: zero-extend [31:0].
  - 011 LD: full XLEN.
  - For XLEN=32, 110 and 011 behave as LW.
  - 111 → unshifted mem_rdata.
  - Misaligned accesses are not trapped; bytes shifted past the top read as zero.
- Register update at posedge clk, in priority order:
  - flush=1 → wb_valid←0, rd_we←0, data and address unchanged. Flush wins over stall.
  - else stall=1 → hold every register.
  - else capture:
    - wb_valid←in_valid.
    - rd_waddr←rd_addr.
    - rd_data←selected result.
    - rd_we←in_valid & reg_write & (rd_addr≠0).
- Latency: exactly 1 cycle from input to rd_data/rd_we.
- rd_we is never 1 with rd_waddr=0.
- instret:
  - Increments by 1 on every edge that captures with in_valid=1, stall=0 and flush=0.
  - Wraps at 2^CNT_W.
  - Unaffected by reg_write.
- Reset asserted mid-operation clears state at once. The first capture after deassertion behaves normally.

Test Plan:
- Reset, then in_valid=1, wb_sel=0, alu_result=0x1234, rd_addr=5, reg_write=1 → next cycle: rd_we=1, rd_waddr=5, rd_data=0x1234, instret=1.
- LB/LBU: mem_rdata=0x80FF7F01, alu_result=...2:
  - funct3=000 → rd_data=0x000000FF... (byte 0xFF sign-extended) = 0xFFFFFFFF.
  - funct3=100 → 0x000000FF.
  - LH at off=2, funct3=001 → 0xFFFF80FF.
- wb_sel sweep with pc=0x100, imm=0x20 → sel 2 gives 0x104, sel 3 gives 0x20, sel 4 gives 0x120, sel 6 gives alu_result.
- rd_addr=0, reg_write=1, in_valid=1 → rd_we=0, wb_valid=1, instret increments.
- Stall and flush:
  - stall=1 for 3 cycles with changing inputs → outputs and instret frozen.
  - stall=1 together with flush=1 → wb_valid=0, rd_we=0, instret unchanged.
- Wrap: CNT_W=4, 17 valid captures → instret=1; then assert reset asynchronously mid-cycle → all outputs 0 before the next edge.
